jk_sync_counter: RTL and testbench
==================================

JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = count up, 0 = count down.
REQ-007 load  input  1  parallel-load strobe (present only with JK_CNT_LOAD_EN).
REQ-008 load_val  input  WIDTH  parallel-load value (present only with JK_CNT_LOAD_EN).
REQ-009 q  output  WIDTH  current count, driven directly from the JK cell outputs.
REQ-010 tc  output  1  terminal count, combinational.
REQ-011 wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-012 Each bit of q SHALL be held in one JK cell with standard JK behaviour: J=0/K=0 hold, J=0/K=1 clear, J=1/K=0 set, J=1/K=1 toggle.
REQ-013 Steady counting SHALL drive J=K=toggle_i per bit, where toggle_i is the synchronous up/down carry/borrow term for bit i.
REQ-014 Priority per edge SHALL be: reset > load > wrap > count > hold.
REQ-015 en=1, up=1, q<MODULUS-1: q SHALL become q+1 at the next edge (latency 1 cycle).
REQ-016 en=1, up=0, q>0: q SHALL become q-1 at the next edge.
REQ-017 Up wrap: en=1, up=1, q==MODULUS-1 -> q SHALL become 0 by driving J=0/K=1 on set bits.
REQ-018 Down wrap: en=1, up=0, q==0 -> q SHALL become MODULUS-1 by driving J=1/K=0 on the required bits.
REQ-019 en=0 with load=0: q SHALL hold, with J=K=0 on all bits.
REQ-020 tc SHALL be 1 when (up=1 and q==MODULUS-1) or (up=0 and q==0), independent of en.
REQ-021 wrap SHALL be 1 for exactly the one cycle following an edge on which REQ-017 or REQ-018 was taken, else 0.
REQ-022 A direction change SHALL take effect on the next edge with no lost or duplicate count.
REQ-023 If q ever holds a value >= MODULUS, the next enabled up count SHALL force q to 0, and the next enabled down count SHALL force q to MODULUS-1.

Reset
REQ-024 With reset=1 at a posedge: q SHALL become 0 and wrap SHALL become 0, regardless of en and load.
REQ-025 Reset asserted mid-count SHALL discard the pending count or load, with no wrap pulse.
REQ-026 tc SHALL read 1 after reset while up=1 only if MODULUS-1==0, which cannot occur; tc therefore reads up==0.

Configuration
REQ-027 Macro JK_CNT_LOAD_EN defined: load and load_val ports SHALL exist.
REQ-028 With JK_CNT_LOAD_EN, load=1 SHALL set q to load_val at the next edge via per-bit J=load_val[i], K=~load_val[i], overriding en.
REQ-029 With JK_CNT_LOAD_EN, a load_val >= MODULUS SHALL be saturated to MODULUS-1.
REQ-030 With JK_CNT_LOAD_EN, a load SHALL never produce a wrap pulse.
REQ-031 Macro undefined: load and load_val ports SHALL be absent, and the behaviour SHALL equal load=0.

Structure
REQ-032 Package jk_pkg SHALL hold the typedef jk_in_t (struct j, k), the localparam JK_HOLD/JK_CLR/JK_SET/JK_TGL encodings, and the function that computes the JK drive.
REQ-033 Sub-module jk_cell (clk, reset, j, k, q) SHALL implement one flip-flop, with reset to 0, and SHALL be instantiated WIDTH times.
REQ-034 A parameter out of the range in REQ-002 SHALL trigger an elaboration-time $error.

Verification
REQ-035 Reset then en=1, up=1 for 12 cycles -> q = 1..9, 0, 1, 2; wrap=1 only in the cycle after q goes 9->0; tc=1 while q=9.
REQ-036 en=1, up=0 from q=0 -> q=9 on the next edge, wrap pulse, then 8, 7.
REQ-037 q=5, en toggles 1,0,0,1 -> q = 6, 6, 6, 7; J=K=0 on held cycles.
REQ-038 With JK_CNT_LOAD_EN: load=1, load_val=7, en=1 -> q=7, no wrap; load_val=13 -> q=9.
REQ-039 Reset=1 asserted while q=9, up=1, en=1 -> q=0 and wrap=0 on that edge; counting resumes from 0 once reset=0.
REQ-040 Up/down flip at q=3 every cycle -> q alternates 4, 3, 4, 3, with no skipped values.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and JK drive encodings for the JK-flip-flop based modulo counter.
package jk_pkg;

  typedef struct packed {
    logic j;
    logic k;
  } jk_in_t;

  localparam jk_in_t JK_HOLD = 2'b00;
  localparam jk_in_t JK_CLR  = 2'b01;
  localparam jk_in_t JK_SET  = 2'b10;
  localparam jk_in_t JK_TGL  = 2'b11;

  // Forced bits steer the cell straight to a target value; otherwise toggle or hold.
  function automatic jk_in_t jk_drive(input logic force_en, input logic target,
                                      input logic toggle);
    if (force_en) return target ? JK_SET : JK_CLR;
    return toggle ? JK_TGL : JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle of jk_sync_counter. Load signals exist only when
// JK_CNT_LOAD_EN is defined.
interface jk_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
`ifdef JK_CNT_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_val;
`endif
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

`ifdef JK_CNT_LOAD_EN
  modport master (output en, up, load, load_val, input q, tc, wrap);
  modport slave  (input en, up, load, load_val, output q, tc, wrap);
`else
  modport master (output en, up, input q, tc, wrap);
  modport slave  (input en, up, output q, tc, wrap);
`endif
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_sync_counter.sv
// Up/down modulo-MODULUS counter built from WIDTH JK cells.
// Optional parallel load is enabled by defining JK_CNT_LOAD_EN.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               reset,
  jk_sync_counter_if.slave   bus
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("jk_sync_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_cell;
  logic [WIDTH-1:0] tog;
  jk_in_t           drive [WIDTH];
  logic             load_act;
  logic [WIDTH-1:0] load_sat;
  logic             wrap_r;

`ifdef JK_CNT_LOAD_EN
  assign load_act = bus.load;
  assign load_sat = (bus.load_val > MAX) ? MAX : bus.load_val;
`else
  assign load_act = 1'b0;
  assign load_sat = '0;
`endif

  // Ripple-free carry/borrow: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    tog[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tog[i] = tog[i-1] & (bus.up ? q_cell[i-1] : ~q_cell[i-1]);
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      drive[i] = JK_HOLD;
      if (load_act) begin
        drive[i] = jk_drive(1'b1, load_sat[i], 1'b0);
      end else if (bus.en) begin
        if (bus.up && q_cell >= MAX) begin
          drive[i] = JK_CLR;
        end else if (!bus.up && (q_cell == '0 || q_cell > MAX)) begin
          drive[i] = jk_drive(1'b1, MAX[i], 1'b0);
        end else begin
          drive[i] = jk_drive(1'b0, 1'b0, tog[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (drive[g].j),
      .k     (drive[g].k),
      .q     (q_cell[g])
    );
  end

  assign bus.q  = q_cell;
  assign bus.tc = bus.up ? (q_cell == MAX) : (q_cell == '0);

  // tc coincides exactly with the wrap condition, so the pulse just registers it.
  always_ff @(posedge clk) begin
    if (reset) wrap_r <= 1'b0;
    else       wrap_r <= bus.en && bus.tc && !load_act;
  end

  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter: driver pushes model expectations,
// monitor pops and compares one entry per clock.
module tb_jk_sync_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  typedef struct {
    int   q;
    logic tc;
    logic wrap;
    int   id;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_q = 0;
  int   step_id = 0;
  bit   done = 1'b0;

  jk_sync_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_sync_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and record the expected post-edge view.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
    exp_t x;
    int   nq;
    bit   w;
    @(negedge clk);
    reset  = r;
    bus.en = e;
    bus.up = u;
`ifdef JK_CNT_LOAD_EN
    bus.load     = l;
    bus.load_val = WIDTH'(lv);
`else
    l = 1'b0;
`endif
    w = 1'b0;
    if (r)      nq = 0;
    else if (l) nq = (lv > MODULUS - 1) ? MODULUS - 1 : lv;
    else if (e) begin
      if (u) begin
        w  = (model_q == MODULUS - 1);
        nq = (model_q >= MODULUS - 1) ? 0 : model_q + 1;
      end else begin
        w  = (model_q == 0);
        nq = (model_q == 0 || model_q >= MODULUS) ? MODULUS - 1 : model_q - 1;
      end
    end else nq = model_q;
    model_q = nq;
    x.q    = nq;
    x.wrap = w;
    x.tc   = u ? (nq == MODULUS - 1) : (nq == 0);
    x.id   = step_id++;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if (int'(bus.q) != x.q) begin
        errors++;
        $display("FAIL q step %0d: got %0d want %0d", x.id, bus.q, x.q);
      end
      checks++;
      if (bus.tc !== x.tc) begin
        errors++;
        $display("FAIL tc step %0d: got %b want %b", x.id, bus.tc, x.tc);
      end
      checks++;
      if (bus.wrap !== x.wrap) begin
        errors++;
        $display("FAIL wrap step %0d: got %b want %b", x.id, bus.wrap, x.wrap);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    bus.en = 1'b0;
    bus.up = 1'b1;
`ifdef JK_CNT_LOAD_EN
    bus.load     = 1'b0;
    bus.load_val = '0;
`endif
    // Reset, then 12 up counts through the 9->0 wrap.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
    // Down from 0: 9 with wrap, then 8, 7.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    // Hold behaviour at 5 with en 1,0,0,1.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    // Direction flip at 3.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, (i % 2) == 0, 0, 0);
    // Reset while sitting on the terminal count.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
`ifdef JK_CNT_LOAD_EN
    step(0, 1, 1, 1, 7);
    step(0, 1, 1, 1, 13);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 15);
`endif
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 40) == 0, ($urandom % 4) != 0, $urandom % 2,
           ($urandom % 10) == 0, int'($urandom_range(0, 2 ** WIDTH - 1)));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left want 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: done %b want 1", done);
      $fatal(1, "timeout");
    end
  end

endmodule
